seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
Parametrised radix-2 shift-add multiplier coprocessor for the pipelined CPU.
- Replaces the software repeated-add multiply loop (LD / ADD / BRA) with a single start/done transaction.
- Supports signed and unsigned operands and returns a full double-width product plus an overflow flag.
- Sits beside the ALU in the EX stage; the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width in bits (>= 4); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  high from the edge after start is accepted until done
done  output  1  single-cycle pulse; product valid
product  output  2*WIDTH  result, held until the next accepted start
overflow  output  1  result does not fit in WIDTH bits, held with product

Behaviour:
Reset (async, any state):
- state=IDLE; busy, done, overflow = 0; product = 0; internal registers cleared.
- Reset mid-operation aborts the multiply; done does not fire.

States: IDLE -> RUN -> FINISH -> IDLE.
- IDLE, on start=1:
  - Capture magnitudes: |a| and |b| if signed_mode, else a and b.
  - Signed magnitude uses WIDTH unsigned bits, so -2^(WIDTH-1) gives 2^(WIDTH-1).
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]) and latch signed_mode.
  - Clear accumulator and counter; busy=1; go to RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - If the multiplier LSB=1, acc += mcand << cnt (2*WIDTH-bit add, no truncation).
  - Shift the multiplier right by 1; cnt++.
  - After WIDTH iterations go to FINISH.
- FINISH:
  - product <= neg ? -acc : acc (two's complement, 2*WIDTH bits).
  - Unsigned overflow = (upper WIDTH bits != 0).
  - Signed overflow = (upper WIDTH+1 bits not all equal).
  - done=1 for this cycle only; busy=0 at the same edge; go to IDLE.

Timing and handshake:
- Latency: done is high in the cycle following the (WIDTH+1)th rising edge after the edge that sampled start.
- start while busy=1 is ignored; no queueing, no error.
- start asserted in the done cycle is accepted (back-to-back operation).
- start held high continuously restarts once per completed operation.
- Operands are not required to be stable after the accepting edge.
- A zero operand takes full latency, gives product=0 and overflow=0 (unless early termination is enabled).

Optional Feature:
SEQ_MULT_EARLY_TERM_EN
- Defined:
  - RUN exits to FINISH after the cycle in which the shifted multiplier becomes zero.
  - RUN lasts max(1, index of highest set bit of |b| + 1) cycles, so latency = that + 1 edges.
  - Results are identical to the non-early-termination build.
- Undefined: fixed WIDTH+1 latency as above; the zero-detect logic is not synthesised.

Test Plan:
- Unsigned 13*15 (a=0x0000000D, b=0x0000000F, WIDTH=32) -> done exactly 33 edges after start; product=0x00000000_000000C3 (195); overflow=0; busy low in the done cycle.
- Signed -1*-1 -> product=0x1, overflow=0. Signed 0x80000000*0xFFFFFFFF -> product=0x00000000_80000000, overflow=1. Signed 7*-3 -> product=0xFFFFFFFF_FFFFFFEB, overflow=0.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE_00000001, overflow=1; same operands signed -> product=0x1, overflow=0.
- Start pulse at cycle 10 of a running op with different operands -> ignored; original result delivered. Start asserted in the done cycle -> second result after another 33 edges.
- Reset raised at cycle 5 of RUN -> busy, done, product, overflow all 0 immediately (asynchronously); after release a fresh 13*15 completes correctly.
- With SEQ_MULT_EARLY_TERM_EN: 13*15 -> done 5 edges after start; b=0 -> done 2 edges after start, product=0; b=0x80000000 unsigned -> 33 edges.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier coprocessor.
//
// Takes one multiplier bit per cycle, LSB first, and accumulates a full
// double-width product. Signed operands are handled by multiplying their
// magnitudes and negating the result at the end.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   request pulse, sampled only while busy=0
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   a            in   [WIDTH-1:0]   multiplicand
//   b            in   [WIDTH-1:0]   multiplier
//   busy         out  high from the accepting edge until done
//   done         out  single-cycle pulse, product valid
//   product      out  [2*WIDTH-1:0] result, held until overwritten
//   overflow     out  result does not fit in WIDTH bits
//
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero. Results are identical; only latency changes.
module seq_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t           state_q,    state_d;
   logic [PW-1:0]    mcand_q,    mcand_d;
   logic [WIDTH-1:0] mplier_q,   mplier_d;
   logic [PW-1:0]    acc_q,      acc_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             neg_q,      neg_d;
   logic             smode_q,    smode_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic [PW-1:0]    product_q,  product_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [PW-1:0]    result;
   logic [WIDTH:0]   sign_bits;
   logic             last_iter;

   // Magnitude stays WIDTH bits unsigned, so the most negative value maps
   // onto 2^(WIDTH-1) without needing an extra bit.
   assign mag_a     = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign result    = neg_q ? -acc_q : acc_q;
   assign sign_bits = result[PW-1:WIDTH-1];

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      smode_d    = smode_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      product_d  = product_q;
      overflow_d = overflow_q;
      last_iter  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, mag_a};
               mplier_d = mag_b;
               neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               smode_d  = signed_mode;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end

         RUN: begin
            // mcand_q is pre-shifted each cycle, so it always equals
            // the multiplicand shifted left by the iteration count.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            cnt_d     = cnt_q + 1'b1;
            last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
            last_iter = last_iter | (mplier_d == '0);
`endif
            if (last_iter) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            product_d = result;
            if (smode_q) begin
               overflow_d = !((sign_bits == '0) || (sign_bits == '1));
            end else begin
               overflow_d = (result[PW-1:WIDTH] != '0);
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         smode_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         smode_q    <= smode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign product  = product_q;
   assign overflow = overflow_q;

endmodule
